// File: rtl/fx_pkg.sv
// Shared FSM state type and elaboration helpers for the iterative fixed-point divider.
package fx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } fx_state_e;

    // Largest positive two's complement value of the given width, zero-extended to 64 bits.
    function automatic logic [63:0] fx_sat_max(input int unsigned width);
        return (64'd1 << (width - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] fx_sat_min(input int unsigned width);
        return 64'd1 << (width - 1);
    endfunction

    function automatic int unsigned fx_iters(input int unsigned width, input int unsigned qfrac,
                                             input int unsigned bpc);
        return (width + qfrac) / bpc;
    endfunction

    function automatic bit fx_bpc_legal(input int unsigned width, input int unsigned qfrac,
                                        input int unsigned bpc);
        return ((bpc == 1) || (bpc == 2) || (bpc == 4)) && (((width + qfrac) % bpc) == 0);
    endfunction

endpackage

// File: rtl/fx_div_step.sv
// Combinational restoring-division slice: resolves BPC quotient bits, MSB first.
module fx_div_step #(
    parameter int unsigned W   = 32,
    parameter int unsigned BPC = 1
) (
    input  logic [W-1:0]   rem_i,
    input  logic [W-1:0]   den_i,
    input  logic [BPC-1:0] bits_i,
    output logic [W-1:0]   rem_o,
    output logic [BPC-1:0] q_o
);

    logic [W:0]   trial;
    logic [W-1:0] part;

    // Partial remainder stays below den_i, so W bits hold it between steps.
    always_comb begin
        part  = rem_i;
        trial = '0;
        q_o   = '0;
        for (int i = int'(BPC) - 1; i >= 0; i--) begin
            trial = {part, bits_i[i]};
            if (trial >= {1'b0, den_i}) begin
                trial  = trial - {1'b0, den_i};
                q_o[i] = 1'b1;
            end
            part = trial[W-1:0];
        end
        rem_o = part;
    end

endmodule

// File: rtl/fx_div_iter.sv
// Signed Q(QINT.QFRAC) iterative restoring divider with valid/ready handshakes and saturation.
// Define FX_DIV_ROUND_EN to round half away from zero instead of truncating toward zero.
module fx_div_iter
    import fx_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned QINT  = 16,
    parameter int unsigned QFRAC = WIDTH - QINT,
    parameter int unsigned BPC   = 1,
    parameter int unsigned TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] numerator,
    input  logic [WIDTH-1:0] denominator,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [TAG_W-1:0] out_tag,
    output logic             div_zero,
    output logic             ovf
);

    localparam int unsigned      N      = WIDTH + QFRAC;
    localparam int unsigned      ITERS  = fx_iters(WIDTH, QFRAC, BPC);
    localparam int unsigned      CNT_W  = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(ITERS - 1);
    localparam logic [WIDTH-1:0] FX_MAX = WIDTH'(fx_sat_max(WIDTH));
    localparam logic [WIDTH-1:0] FX_MIN = WIDTH'(fx_sat_min(WIDTH));

    if (!fx_bpc_legal(WIDTH, QFRAC, BPC)) begin : g_bpc_illegal
        $error("fx_div_iter: BPC must be 1, 2 or 4 and divide WIDTH+QFRAC");
    end

    fx_state_e        state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [N-1:0]     dq_q, dq_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] den_q, den_d;
    logic             neg_q, neg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;
    logic             div_zero_q, div_zero_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] num_mag, den_mag;
    logic [WIDTH-1:0] step_rem;
    logic [BPC-1:0]   step_q;
    logic [N-1:0]     q_nx, q_fin;
    logic             sat_ovf;
    logic [WIDTH-1:0] sat_res;

    assign num_mag = numerator[WIDTH-1]   ? (~numerator + WIDTH'(1))   : numerator;
    assign den_mag = denominator[WIDTH-1] ? (~denominator + WIDTH'(1)) : denominator;

    // dq_q shifts dividend bits out of the top while quotient bits fill in from the bottom.
    fx_div_step #(
        .W   (WIDTH),
        .BPC (BPC)
    ) u_step (
        .rem_i  (rem_q),
        .den_i  (den_q),
        .bits_i (dq_q[N-1 -: BPC]),
        .rem_o  (step_rem),
        .q_o    (step_q)
    );

    assign q_nx = {dq_q[N-BPC-1:0], step_q};

    // Final magnitude (optionally rounded), sign application and saturation for the DONE entry.
    always_comb begin
        q_fin   = q_nx;
        sat_ovf = 1'b0;
        sat_res = '0;
`ifdef FX_DIV_ROUND_EN
        if ({step_rem, 1'b0} >= {1'b0, den_q}) begin
            q_fin = q_nx + N'(1);
        end
`endif
        if (neg_q) begin
            sat_ovf = (|q_fin[N-1:WIDTH]) || (q_fin[WIDTH-1] && (|q_fin[WIDTH-2:0]));
        end else begin
            sat_ovf = |q_fin[N-1:WIDTH-1];
        end
        if (sat_ovf) begin
            sat_res = neg_q ? FX_MIN : FX_MAX;
        end else if (neg_q) begin
            sat_res = ~q_fin[WIDTH-1:0] + WIDTH'(1);
        end else begin
            sat_res = q_fin[WIDTH-1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        dq_d        = dq_q;
        rem_d       = rem_q;
        den_d       = den_q;
        neg_d       = neg_q;
        cnt_d       = cnt_q;
        result_d    = result_q;
        out_tag_d   = out_tag_q;
        div_zero_d  = div_zero_q;
        ovf_d       = ovf_q;
        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    neg_d      = numerator[WIDTH-1] ^ denominator[WIDTH-1];
                    den_d      = den_mag;
                    dq_d       = {num_mag, {QFRAC{1'b0}}};
                    rem_d      = '0;
                    cnt_d      = '0;
                    out_tag_d  = in_tag;
                    in_ready_d = 1'b0;
                    if (denominator == '0) begin
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                        result_d    = numerator[WIDTH-1] ? FX_MIN : FX_MAX;
                        div_zero_d  = 1'b1;
                        ovf_d       = 1'b0;
                    end else begin
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                dq_d  = q_nx;
                rem_d = step_rem;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    result_d    = sat_res;
                    ovf_d       = sat_ovf;
                    div_zero_d  = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            dq_q        <= '0;
            rem_q       <= '0;
            den_q       <= '0;
            neg_q       <= 1'b0;
            cnt_q       <= '0;
            result_q    <= '0;
            out_tag_q   <= '0;
            div_zero_q  <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            dq_q        <= dq_d;
            rem_q       <= rem_d;
            den_q       <= den_d;
            neg_q       <= neg_d;
            cnt_q       <= cnt_d;
            result_q    <= result_d;
            out_tag_q   <= out_tag_d;
            div_zero_q  <= div_zero_d;
            ovf_q       <= ovf_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign out_tag   = out_tag_q;
    assign div_zero  = div_zero_q;
    assign ovf       = ovf_q;

endmodule
